// File: rtl/hash_table_mc.sv
// Multi-cycle chained hash table: TOTAL_INDEX buckets x CHAINING_SIZE register slots,
// one slot probed per cycle, with insert/update, delete, search and bulk clear.
module hash_table_mc #(
   parameter int unsigned KEY_WIDTH      = 32,
   parameter int unsigned VALUE_WIDTH    = 32,
   parameter int unsigned TOTAL_INDEX    = 8,
   parameter int unsigned CHAINING_SIZE  = 4,
   parameter string       HASH_ALGORITHM = "MODULUS",
   localparam int unsigned INDEX_WIDTH   = $clog2(TOTAL_INDEX),
   localparam int unsigned CNT_W         = $clog2(CHAINING_SIZE + 1),
   localparam int unsigned ENT_W         = $clog2(TOTAL_INDEX * CHAINING_SIZE + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [KEY_WIDTH-1:0]   key_in,
   input  logic [VALUE_WIDTH-1:0] value_in,
   input  logic [1:0]             op_sel,
   input  logic                   op_en,
   output logic                   op_ready,
   output logic [VALUE_WIDTH-1:0] value_out,
   output logic                   op_done,
   output logic                   op_error,
   output logic [CNT_W-1:0]       collision_count,
   output logic [ENT_W-1:0]       entry_count,
   output logic                   full
);

   localparam int unsigned PROBE_W    = $clog2(CHAINING_SIZE);
   localparam int unsigned NUM_CHUNKS = (KEY_WIDTH + INDEX_WIDTH - 1) / INDEX_WIDTH;
   localparam int unsigned MaxEntries = TOTAL_INDEX * CHAINING_SIZE;
   localparam logic [PROBE_W-1:0] LastSlot = PROBE_W'(CHAINING_SIZE - 1);

   typedef enum logic [1:0] {StIdle, StProbe, StClear} state_e;
   typedef enum logic [1:0] {
      OpInsert = 2'b00,
      OpDelete = 2'b01,
      OpSearch = 2'b10,
      OpClear  = 2'b11
   } op_e;

   function automatic logic [INDEX_WIDTH-1:0] hash_index(input logic [KEY_WIDTH-1:0] key);
      logic [NUM_CHUNKS*INDEX_WIDTH-1:0] padded;
      logic [INDEX_WIDTH-1:0]            fold;
      int unsigned                       wide;
      padded                 = '0;
      padded[KEY_WIDTH-1:0]  = key;
      fold                   = '0;
      if (HASH_ALGORITHM == "XOR_FOLD") begin
         for (int i = 0; i < NUM_CHUNKS; i++) begin
            fold ^= padded[i*INDEX_WIDTH +: INDEX_WIDTH];
         end
         wide = 32'(fold);
         return INDEX_WIDTH'(wide % TOTAL_INDEX);
      end
      return INDEX_WIDTH'(key % KEY_WIDTH'(TOTAL_INDEX));
   endfunction

   logic [KEY_WIDTH-1:0]   key_mem [TOTAL_INDEX][CHAINING_SIZE];
   logic [VALUE_WIDTH-1:0] val_mem [TOTAL_INDEX][CHAINING_SIZE];

   state_e                                  state_q, state_d;
   op_e                                     op_q, op_d;
   logic [KEY_WIDTH-1:0]                    key_q, key_d;
   logic [VALUE_WIDTH-1:0]                  value_q, value_d;
   logic [INDEX_WIDTH-1:0]                  bucket_q, bucket_d;
   logic [PROBE_W-1:0]                      probe_q, probe_d;
   logic                                    free_found_q, free_found_d;
   logic [PROBE_W-1:0]                      free_idx_q, free_idx_d;
   logic [TOTAL_INDEX-1:0][CHAINING_SIZE-1:0] valid_q, valid_d;
   logic [VALUE_WIDTH-1:0]                  value_out_q, value_out_d;
   logic                                    done_q, done_d;
   logic                                    error_q, error_d;
   logic [CNT_W-1:0]                        coll_q, coll_d;
   logic [ENT_W-1:0]                        entry_q, entry_d;
   logic                                    full_q, full_d;

   logic               hit, last, free_here, mem_we;
   logic [PROBE_W-1:0] free_slot, mem_slot;

   always_comb begin
      hit       = valid_q[bucket_q][probe_q] && (key_mem[bucket_q][probe_q] == key_q);
      last      = (probe_q == LastSlot);
      free_here = !valid_q[bucket_q][probe_q];
      // Lowest free slot seen so far, including the one probed this cycle.
      free_slot = free_found_q ? free_idx_q : probe_q;
   end

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      key_d        = key_q;
      value_d      = value_q;
      bucket_d     = bucket_q;
      probe_d      = probe_q;
      free_found_d = free_found_q;
      free_idx_d   = free_idx_q;
      valid_d      = valid_q;
      value_out_d  = value_out_q;
      done_d       = 1'b0;
      error_d      = error_q;
      coll_d       = coll_q;
      entry_d      = entry_q;
      mem_we       = 1'b0;
      mem_slot     = probe_q;
      unique case (state_q)
         StIdle: begin
            if (op_en) begin
               op_d         = op_e'(op_sel);
               key_d        = key_in;
               value_d      = value_in;
               bucket_d     = hash_index(key_in);
               probe_d      = '0;
               free_found_d = 1'b0;
               free_idx_d   = '0;
               state_d      = (op_e'(op_sel) == OpClear) ? StClear : StProbe;
            end
         end
         StClear: begin
            valid_d = '0;
            entry_d = '0;
            error_d = 1'b0;
            coll_d  = '0;
            done_d  = 1'b1;
            state_d = StIdle;
         end
         StProbe: begin
            if (hit) begin
               error_d = 1'b0;
               coll_d  = CNT_W'(probe_q);
               done_d  = 1'b1;
               state_d = StIdle;
               if (op_q == OpInsert) begin
                  mem_we = 1'b1;
               end else if (op_q == OpSearch) begin
                  value_out_d = val_mem[bucket_q][probe_q];
               end else begin
                  valid_d[bucket_q][probe_q] = 1'b0;
                  entry_d                    = entry_q - ENT_W'(1);
               end
            end else if (last) begin
               done_d  = 1'b1;
               state_d = StIdle;
               if ((op_q == OpInsert) && (free_found_q || free_here)) begin
                  mem_we                       = 1'b1;
                  mem_slot                     = free_slot;
                  valid_d[bucket_q][free_slot] = 1'b1;
                  entry_d                      = entry_q + ENT_W'(1);
                  error_d                      = 1'b0;
                  coll_d                       = CNT_W'(free_slot);
               end else begin
                  error_d = 1'b1;
                  coll_d  = CNT_W'(CHAINING_SIZE);
               end
            end else begin
               if (free_here && !free_found_q) begin
                  free_found_d = 1'b1;
                  free_idx_d   = probe_q;
               end
               probe_d = probe_q + PROBE_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
      full_d = (entry_d == ENT_W'(MaxEntries));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         op_q         <= OpInsert;
         key_q        <= '0;
         value_q      <= '0;
         bucket_q     <= '0;
         probe_q      <= '0;
         free_found_q <= 1'b0;
         free_idx_q   <= '0;
         valid_q      <= '0;
         value_out_q  <= '0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         coll_q       <= '0;
         entry_q      <= '0;
         full_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         key_q        <= key_d;
         value_q      <= value_d;
         bucket_q     <= bucket_d;
         probe_q      <= probe_d;
         free_found_q <= free_found_d;
         free_idx_q   <= free_idx_d;
         valid_q      <= valid_d;
         value_out_q  <= value_out_d;
         done_q       <= done_d;
         error_q      <= error_d;
         coll_q       <= coll_d;
         entry_q      <= entry_d;
         full_q       <= full_d;
      end
   end

   // Key/value storage carries no reset; validity lives only in valid_q.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         key_mem[bucket_q][mem_slot] <= key_q;
         val_mem[bucket_q][mem_slot] <= value_q;
      end
   end

   assign op_ready        = (state_q == StIdle);
   assign value_out       = value_out_q;
   assign op_done         = done_q;
   assign op_error        = error_q;
   assign collision_count = coll_q;
   assign entry_count     = entry_q;
   assign full            = full_q;

endmodule

// File: tb/tb_hash_table_mc.sv
// Directed plus random checks of hash_table_mc against a slot-array reference model.
module tb_hash_table_mc;

   localparam int TI = 8;
   localparam int CS = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] key_in = '0;
   logic [31:0] value_in = '0;
   logic [1:0]  op_sel = '0;
   logic        op_en = 1'b0;
   logic        op_ready;
   logic [31:0] value_out;
   logic        op_done;
   logic        op_error;
   logic [2:0]  collision_count;
   logic [5:0]  entry_count;
   logic        full;

   int n_cmp = 0;
   int n_fail = 0;

   bit          mvalid [TI][CS];
   logic [31:0] mkey   [TI][CS];
   logic [31:0] mval   [TI][CS];
   int          ment;
   logic [31:0] mvout;

   always #5 clk = ~clk;

   hash_table_mc #(
      .KEY_WIDTH     (32),
      .VALUE_WIDTH   (32),
      .TOTAL_INDEX   (TI),
      .CHAINING_SIZE (CS),
      .HASH_ALGORITHM("MODULUS")
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .key_in         (key_in),
      .value_in       (value_in),
      .op_sel         (op_sel),
      .op_en          (op_en),
      .op_ready       (op_ready),
      .value_out      (value_out),
      .op_done        (op_done),
      .op_error       (op_error),
      .collision_count(collision_count),
      .entry_count    (entry_count),
      .full           (full)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < TI; b++) begin
         for (int s = 0; s < CS; s++) mvalid[b][s] = 1'b0;
      end
      ment  = 0;
      mvout = '0;
   endtask

   task automatic do_op(input logic [1:0] op, input logic [31:0] k, input logic [31:0] v,
                        input string tag);
      int   b, hit, free, exp_lat, exp_coll, lat, w;
      logic exp_err;
      b    = int'(k % TI);
      hit  = -1;
      free = -1;
      for (int s = CS - 1; s >= 0; s--) begin
         if (mvalid[b][s] && mkey[b][s] == k) hit = s;
         if (!mvalid[b][s]) free = s;
      end
      if (op == 2'b11) begin
         model_reset_keep_vout();
         exp_lat = 2; exp_err = 1'b0; exp_coll = 0;
      end else if (hit >= 0) begin
         exp_lat = hit + 2; exp_err = 1'b0; exp_coll = hit;
         if (op == 2'b00) mval[b][hit] = v;
         else if (op == 2'b10) mvout = mval[b][hit];
         else begin mvalid[b][hit] = 1'b0; ment--; end
      end else begin
         exp_lat = CS + 1;
         if (op == 2'b00 && free >= 0) begin
            exp_err = 1'b0; exp_coll = free;
            mvalid[b][free] = 1'b1; mkey[b][free] = k; mval[b][free] = v; ment++;
         end else begin
            exp_err = 1'b1; exp_coll = CS;
         end
      end

      w = 0;
      while (!op_ready && w < 50) begin @(posedge clk); #1; w++; end
      check({tag, ".ready"}, op_ready, 1);
      @(negedge clk);
      key_in = k; value_in = v; op_sel = op; op_en = 1'b1;
      @(posedge clk);
      lat = 1;
      #1;
      while (lat < 20) begin
         // Busy-time requests and input churn must be ignored.
         op_en    = 1'($urandom_range(0, 1));
         key_in   = $urandom;
         value_in = $urandom;
         op_sel   = 2'($urandom);
         @(posedge clk);
         lat++;
         #1;
         op_en = 1'b0;
         if (op_done) break;
      end
      op_en = 1'b0;
      check({tag, ".lat"}, lat, exp_lat);
      check({tag, ".err"}, op_error, exp_err);
      check({tag, ".coll"}, collision_count, exp_coll);
      check({tag, ".ent"}, entry_count, ment);
      check({tag, ".full"}, full, (ment == TI * CS));
      check({tag, ".vout"}, value_out, mvout);
   endtask

   task automatic model_reset_keep_vout();
      logic [31:0] keep;
      keep = mvout;
      model_reset();
      mvout = keep;
   endtask

   initial begin
      logic [31:0] k;
      int r;
      model_reset();
      #1;
      check("rst.ready", op_ready, 1);
      check("rst.done", op_done, 0);
      check("rst.err", op_error, 0);
      check("rst.coll", collision_count, 0);
      check("rst.ent", entry_count, 0);
      check("rst.full", full, 0);
      check("rst.vout", value_out, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;

      do_op(2'b00, 1, 2, "t1_ins");
      check("t1_ins.coll0", collision_count, 0);
      @(posedge clk); #1;
      check("t1_pulse", op_done, 0);
      do_op(2'b10, 1, 0, "t1_srch");
      check("t1_srch.v2", value_out, 2);

      do_op(2'b00, 3, 2, "t2_ins3");
      do_op(2'b00, 11, 3, "t2_ins11");
      do_op(2'b00, 19, 4, "t2_ins19");
      do_op(2'b00, 27, 5, "t2_ins27");
      check("t2_ins27.coll3", collision_count, 3);
      do_op(2'b00, 35, 5, "t2_ins35");
      check("t2_ins35.err", op_error, 1);
      check("t2_ins35.coll4", collision_count, 4);
      check("t2_ins35.ent5", entry_count, 5);

      do_op(2'b00, 11, 9, "t3_upd11");
      check("t3_upd11.coll1", collision_count, 1);
      do_op(2'b10, 11, 0, "t3_srch11");
      check("t3_srch11.v9", value_out, 9);

      do_op(2'b01, 11, 0, "t4_del11");
      do_op(2'b01, 11, 0, "t4_del11b");
      check("t4_del11b.err", op_error, 1);
      do_op(2'b00, 43, 7, "t4_ins43");
      check("t4_ins43.coll1", collision_count, 1);
      do_op(2'b10, 19, 0, "t4_srch19");
      check("t4_srch19.v4", value_out, 4);
      check("t4_srch19.coll2", collision_count, 2);

      do_op(2'b11, 0, 0, "t5_clr");
      check("t5_clr.ent0", entry_count, 0);
      do_op(2'b10, 3, 0, "t5_srch3");
      check("t5_srch3.err", op_error, 1);
      for (int i = 0; i < 32; i++) do_op(2'b00, i, i * 3, $sformatf("t5_fill%0d", i));
      check("t5_full", full, 1);
      do_op(2'b00, 32, 1, "t5_ins32");
      check("t5_ins32.err", op_error, 1);

      do_op(2'b01, 5, 0, "t6_del5");
      @(negedge clk);
      key_in = 45; value_in = 99; op_sel = 2'b00; op_en = 1'b1;
      @(posedge clk); #1;
      op_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      model_reset();
      check("t6.ready", op_ready, 1);
      check("t6.done", op_done, 0);
      check("t6.err", op_error, 0);
      check("t6.coll", collision_count, 0);
      check("t6.ent", entry_count, 0);
      check("t6.full", full, 0);
      check("t6.vout", value_out, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      do_op(2'b10, 45, 0, "t6_srch45");
      do_op(2'b10, 1, 0, "t6_srch1");
      check("t6_srch1.err", op_error, 1);

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) k = 32'hABC0_0000 | 32'($urandom_range(0, 31));
         else k = 32'($urandom_range(0, 47));
         r = $urandom_range(0, 99);
         if (r < 50) do_op(2'b00, k, $urandom, $sformatf("rnd%0d_ins", i));
         else if (r < 70) do_op(2'b01, k, 0, $sformatf("rnd%0d_del", i));
         else if (r < 97) do_op(2'b10, k, 0, $sformatf("rnd%0d_srch", i));
         else do_op(2'b11, 0, 0, $sformatf("rnd%0d_clr", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/hash_table_mc.md
Name: hash_table_mc

Overview:
- Multi-cycle chained hash table, successor to the single-op hash table.
- Adds: op_ready handshake, bulk CLEAR, in-place value update, entry_count/full status, selectable hash.
- Storage is TOTAL_INDEX buckets x CHAINING_SIZE slots (key, value, valid), in registers.
- Sits behind lookup/offload engines as a small CAM-like key/value store.

Parameters:
- KEY_WIDTH, 32, key width in bits.
- VALUE_WIDTH, 32, value width in bits.
- TOTAL_INDEX, 8, number of buckets (>=2).
- CHAINING_SIZE, 4, slots per bucket (>=2).
- HASH_ALGORITHM, "MODULUS", "MODULUS": key mod TOTAL_INDEX; "XOR_FOLD": XOR of all INDEX_WIDTH-bit chunks of key (zero-padded), then mod TOTAL_INDEX.
- Derived: INDEX_WIDTH=$clog2(TOTAL_INDEX), CNT_W=$clog2(CHAINING_SIZE+1), ENT_W=$clog2(TOTAL_INDEX*CHAINING_SIZE+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- key_in  in  KEY_WIDTH  operation key.
- value_in  in  VALUE_WIDTH  insert value.
- op_sel  in  2  00 insert, 01 delete, 10 search, 11 clear-all.
- op_en  in  1  request; accepted when op_en && op_ready at a rising edge.
- op_ready  out  1  high in IDLE.
- value_out  out  VALUE_WIDTH  search result; valid with op_done.
- op_done  out  1  one-cycle completion pulse.
- op_error  out  1  insert: bucket full; delete/search: key not found. Valid with op_done.
- collision_count  out  CNT_W  slot index hit/written; CHAINING_SIZE on error.
- entry_count  out  ENT_W  total valid entries.
- full  out  1  entry_count == TOTAL_INDEX*CHAINING_SIZE.

Behaviour:
- Reset (rst low, asynchronous): all valid bits 0; state IDLE; op_ready=1; value_out=0; op_done=0; op_error=0; collision_count=0; entry_count=0; full=0. Key/value arrays need no reset.
- Accept: key_in, value_in, op_sel and bucket index latched at the accept edge (E0). Later input changes are ignored. op_en while busy is ignored, not queued.
- States: IDLE -> PROBE (ins/del/search) or IDLE -> CLEAR; PROBE/CLEAR -> IDLE. op_done is registered and high for the one cycle after the final edge. op_ready returns high in that same cycle, so back-to-back ops are allowed.
- PROBE: edge En (n>=1) inspects slot p=n-1 of the latched bucket.
- Search/delete end at the first valid key match, or after slot CHAINING_SIZE-1 with no match (op_error=1).
- Delete clears the valid bit of the matched slot. No compaction. entry_count decrements.
- Search drives value_out with the stored value. On error value_out is held.
- Insert end condition:
  - Match: ends at the match, overwrites the value, collision_count=p, entry_count unchanged.
  - No match: always probes all CHAINING_SIZE slots, tracking the lowest free slot. At the last probe, writes the key/value to that slot and increments entry_count.
  - No match and no free slot: op_error=1, table unchanged.
- Latency (accept edge to op_done high):
  - Hit at slot p: p+2 edges.
  - Miss or new insert: CHAINING_SIZE+1 edges.
  - CLEAR: 2 edges. CLEAR zeroes all valid bits and entry_count. op_error=0, collision_count=0.
- Error outputs: op_error and collision_count update only at completion. collision_count=CHAINING_SIZE on any error.
- Keys are compared at full KEY_WIDTH. Key 0 is a legal key.
- full updates the same edge as entry_count.
- op_sel is sampled only at accept.

Test Plan (defaults, MODULUS):
1. Insert(1,2) -> op_done 5 edges after accept, op_error 0, collision_count 0, entry_count 1. Search(1) -> op_done 2 edges after accept, value_out 2.
2. Insert keys 3,11,19,27 (bucket 3) -> collision_count 0,1,2,3. Insert(35,5) -> op_error 1, collision_count 4, entry_count stays 5.
3. Insert(11,9) on an existing key -> collision_count 1, op_done 3 edges after accept, entry_count unchanged. Search(11) -> value_out 9.
4. Delete(11) -> ok. Delete(11) again -> op_error 1. Insert(43,7) -> collision_count 1 (hole reused). Search(19) -> value_out 4, collision_count 2.
5. Clear -> op_done 2 edges after accept, entry_count 0. Search(3) -> op_error 1. Insert keys 0..31 -> full 1 after the 32nd insert; insert 32 -> op_error 1.
6. Drive rst low during PROBE of an insert -> all outputs reset immediately, no write occurs. After rst goes high, op_ready=1 and search of a prior key returns op_error 1.
